// File: rtl/aflag_pkg.sv
// Shared definitions for the aflag_arbiter flag-channel scheduler:
// FSM state encoding and default counter widths.
package aflag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } arb_state_t;

    // Wide enough for GAP up to 256 and TIMEOUT up to 65536 cycles
    localparam int GAP_CNT_W = 8;
    localparam int TO_CNT_W  = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set bit of pending at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   pending,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] sel,
    output logic           valid
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            idx = sum[IDW-1:0];
            if (!valid && pending[idx]) begin
                valid = 1'b1;
                sel   = idx;
            end
        end
    end

endmodule

// File: rtl/aflag_arbiter.sv
// Round-robin scheduler sharing one toggle-synchronised flag channel among N requesters.
// Optional ack timeout is enabled by defining AFLAG_ARB_TIMEOUT_EN.
module aflag_arbiter
    import aflag_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int GAP = 4
`ifdef AFLAG_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   pending,
    output logic           flag_src,
    output logic [IDW-1:0] id,
    input  logic           ack,
    output logic           busy,
    output logic [N-1:0]   done
`ifdef AFLAG_ARB_TIMEOUT_EN
    ,
    output logic           timeout
`endif
);

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
`ifdef AFLAG_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    logic [TO_CNT_W-1:0]  to_cnt;
`endif

    arb_state_t           state;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       ptr_next;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_valid;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [N-1:0]         id_onehot;
    logic [N-1:0]         clear;

    assign id_onehot = N'(1) << id;
    assign clear     = (state == ST_WAIT_ACK && ack) ? id_onehot : '0;
    assign ptr_next  = (id == IDW'(N - 1)) ? '0 : id + IDW'(1);

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .sel     (pick_idx),
        .valid   (pick_valid)
    );

    // A fresh request wins over the clear, so a re-fire during the ack is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= req | (pending & ~clear);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            id       <= '0;
            flag_src <= 1'b0;
            busy     <= 1'b0;
            done     <= '0;
            gap_cnt  <= '0;
`ifdef AFLAG_ARB_TIMEOUT_EN
            to_cnt   <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            flag_src <= 1'b0;
            done     <= '0;
`ifdef AFLAG_ARB_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        id       <= pick_idx;
                        state    <= ST_SEND;
                        flag_src <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT_ACK;
`ifdef AFLAG_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                ST_WAIT_ACK: begin
                    // An ack on the expiry cycle is treated as a normal ack
                    if (ack) begin
                        done    <= id_onehot;
                        ptr     <= ptr_next;
                        gap_cnt <= '0;
                        state   <= (GAP == 0) ? ST_IDLE : ST_GAP;
                        busy    <= (GAP != 0);
                    end
`ifdef AFLAG_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        ptr     <= ptr_next;
                        gap_cnt <= '0;
                        state   <= (GAP == 0) ? ST_IDLE : ST_GAP;
                        busy    <= (GAP != 0);
                    end else begin
                        to_cnt <= to_cnt + TO_CNT_W'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
